// File: rtl/apb_slave_mux_tmo.sv
// APB 1:NPORT slave mux with zero-latency pass-through, unmapped-address error and
// optional access timeout (compiled in by defining APB_MUX_TMO_EN); saturating error counter.
module apb_slave_mux_tmo #(
    parameter int                NPORT      = 4,
    parameter int                DEC_LSB    = 12,
    parameter int                DEC_W      = 4,
    parameter logic [NPORT-1:0]  PORT_EN    = {NPORT{1'b1}},
    parameter int                TMO_CYCLES = 256
) (
    input  logic                  reg_clk,
    input  logic                  reg_rstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [31:0]           paddr,
    output logic                  pready,
    output logic                  pslverr,
    output logic [31:0]           prdata,
    output logic [NPORT-1:0]      psel_s,
    input  logic [NPORT-1:0]      pready_s,
    input  logic [NPORT-1:0]      pslverr_s,
    input  logic [32*NPORT-1:0]   prdata_s,
    input  logic                  tmo_clr,
    output logic                  tmo_flag,
    output logic [DEC_W-1:0]      tmo_port,
    output logic [7:0]            err_cnt
);

    localparam int NDEC = 1 << DEC_W;
    // Enable mask widened to the full decode space so out-of-range indices read as disabled.
    localparam logic [NDEC-1:0] EN_EXT = NDEC'(PORT_EN);

    typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_t;

    state_t            state, state_nxt;
    logic [DEC_W-1:0]  idx;
    logic              dec_vld;
    logic              acc;
    logic              slv_rdy;
    logic              slv_err;
    logic [31:0]       slv_dat;
    logic              tmo_hit;
    logic              done_err;

    assign idx     = paddr[DEC_LSB +: DEC_W];
    assign dec_vld = EN_EXT[idx];
    assign acc     = psel && penable && dec_vld;

    always_comb begin
        slv_rdy = 1'b0;
        slv_err = 1'b0;
        slv_dat = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (idx == DEC_W'(i)) begin
                slv_rdy = pready_s[i];
                slv_err = pslverr_s[i];
                slv_dat = prdata_s[32*i +: 32];
            end
        end
    end

`ifdef APB_MUX_TMO_EN
    localparam int WCW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;

    logic [WCW-1:0] wcnt;

    // Fires on the TMO_CYCLES-th access cycle; a same-cycle slave ready takes priority.
    assign tmo_hit = (state == ACCESS) && acc && !slv_rdy &&
                     (wcnt == WCW'(TMO_CYCLES - 1));

    always_ff @(posedge reg_clk or negedge reg_rstn) begin
        if (!reg_rstn) begin
            wcnt <= '0;
        end else if (!psel || pready) begin
            wcnt <= '0;
        end else if (acc && !slv_rdy && state != ABORT) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    always_ff @(posedge reg_clk or negedge reg_rstn) begin
        if (!reg_rstn) begin
            tmo_flag <= 1'b0;
            tmo_port <= '0;
        end else if (tmo_hit) begin
            tmo_flag <= 1'b1;
            tmo_port <= idx;
        end else if (tmo_clr) begin
            tmo_flag <= 1'b0;
        end
    end
`else
    localparam int unused_tmo_cycles = TMO_CYCLES;

    assign tmo_hit  = 1'b0;
    assign tmo_flag = 1'b0;
    assign tmo_port = '0;
`endif

    always_ff @(posedge reg_clk or negedge reg_rstn) begin
        if (!reg_rstn) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pready    = 1'b1;
        pslverr   = 1'b0;
        prdata    = '0;
        psel_s    = '0;

        case (state)
            IDLE:    if (acc && !slv_rdy) state_nxt = ACCESS;
            ACCESS: begin
                if (!acc || slv_rdy) state_nxt = IDLE;
                else if (tmo_hit)    state_nxt = ABORT;
            end
            ABORT:   if (!psel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        for (int i = 0; i < NPORT; i++) begin
            psel_s[i] = psel && dec_vld && (idx == DEC_W'(i)) && (state != ABORT);
        end

        // A master still holding psel after an abort gets no response until it lets go.
        if (psel) begin
            if (state == ABORT) begin
                pready = 1'b0;
            end else if (!dec_vld || tmo_hit) begin
                pslverr = 1'b1;
            end else begin
                pready  = slv_rdy;
                pslverr = slv_err;
                prdata  = slv_dat;
            end
        end
    end

    assign done_err = psel && penable && pready && pslverr;

    always_ff @(posedge reg_clk or negedge reg_rstn) begin
        if (!reg_rstn) begin
            err_cnt <= '0;
        end else if (tmo_clr) begin
            err_cnt <= {7'd0, done_err};
        end else if (done_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_apb_slave_mux_tmo.sv
// Randomised scoreboard bench for apb_slave_mux_tmo (4 ports, port 2 disabled, 8-cycle timeout).
module tb_apb_slave_mux_tmo;

    localparam int          NPORT = 4;
    localparam logic [3:0]  EN    = 4'b1011;
    localparam int          TMO   = 8;
`ifdef APB_MUX_TMO_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           reg_clk = 1'b0;
    logic           reg_rstn;
    logic           psel, penable;
    logic [31:0]    paddr;
    logic           pready, pslverr;
    logic [31:0]    prdata;
    logic [3:0]     psel_s;
    logic [3:0]     pready_s, pslverr_s;
    logic [127:0]   prdata_s;
    logic           tmo_clr;
    logic           tmo_flag;
    logic [3:0]     tmo_port;
    logic [7:0]     err_cnt;

    apb_slave_mux_tmo #(
        .NPORT(NPORT), .DEC_LSB(12), .DEC_W(4), .PORT_EN(EN), .TMO_CYCLES(TMO)
    ) dut (
        .reg_clk(reg_clk), .reg_rstn(reg_rstn),
        .psel(psel), .penable(penable), .paddr(paddr),
        .pready(pready), .pslverr(pslverr), .prdata(prdata),
        .psel_s(psel_s), .pready_s(pready_s), .pslverr_s(pslverr_s), .prdata_s(prdata_s),
        .tmo_clr(tmo_clr), .tmo_flag(tmo_flag), .tmo_port(tmo_port), .err_cnt(err_cnt)
    );

    always #5 reg_clk = ~reg_clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        logic [3:0]  sel;
        logic [7:0]  err_b;
        logic        flag_b;
        logic [3:0]  port_b;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          mcyc   = 0;
    logic [7:0]  m_err  = '0;
    logic        m_flag = 1'b0;
    logic [3:0]  m_port = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: idle outputs every idle cycle, full response on every completed transfer.
    always @(negedge reg_clk) begin
        if (!psel) begin
            mcyc = 0;
            check("idle_outputs", {psel_s, pready, pslverr, prdata}, {4'b0, 1'b1, 1'b0, 32'h0});
        end else if (penable) begin
            mcyc++;
            if (pready) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("prdata",     prdata,   e.data);
                    check("pslverr",    pslverr,  e.err);
                    check("acc_cycles", mcyc,     e.cyc);
                    check("psel_s",     psel_s,   e.sel);
                    check("err_cnt",    err_cnt,  e.err_b);
                    check("tmo_flag",   tmo_flag, e.flag_b);
                    check("tmo_port",   tmo_port, e.port_b);
                end
                mcyc = 0;
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input int waits, input logic [31:0] data,
                        input logic err, input bit clr);
        int   idx;
        bit   vld, tmo;
        int   k;
        exp_t e;
        idx = int'(addr[15:12]);
        vld = (idx < NPORT) && EN[idx];
        tmo = 1'b0;
        if (!vld) begin
            e.data = '0; e.err = 1'b1; e.cyc = 1;
        end else if (TMO_EN && waits >= TMO) begin
            e.data = '0; e.err = 1'b1; e.cyc = TMO; tmo = 1'b1;
        end else begin
            e.data = data; e.err = err; e.cyc = waits + 1;
        end
        e.sel    = vld ? 4'(1 << idx) : 4'b0;
        e.err_b  = m_err;
        e.flag_b = m_flag;
        e.port_b = m_port;
        sb.push_back(e);

        @(posedge reg_clk); #1;
        paddr     = addr;
        psel      = 1'b1;
        penable   = 1'b0;
        tmo_clr   = 1'b0;
        prdata_s  = {$urandom, $urandom, $urandom, $urandom};
        pslverr_s = 4'($urandom);
        pready_s  = 4'($urandom);
        if (idx < NPORT) begin
            prdata_s[32*idx +: 32] = data;
            pslverr_s[idx]         = err;
        end
        @(posedge reg_clk); #1;
        penable = 1'b1;
        k = 0;
        forever begin
            if (idx < NPORT) pready_s[idx] = (k == waits);
            tmo_clr = clr && (k + 1 == e.cyc);
            @(negedge reg_clk);
            if (pready) break;
            if (k >= 300) begin
                check("xfer_cycle_budget", 64'd1, 64'd0);
                break;
            end
            @(posedge reg_clk); #1;
            k++;
        end

        if (e.err) m_err = clr ? 8'd1 : ((m_err == 8'hFF) ? 8'hFF : m_err + 8'd1);
        else if (clr) m_err = 8'd0;
        if (tmo) begin
            m_flag = 1'b1;
            m_port = 4'(idx);
        end else if (clr) begin
            m_flag = 1'b0;
        end

        @(posedge reg_clk); #1;
        tmo_clr = 1'b0;
        penable = 1'b0;
        if (tmo) begin
            @(negedge reg_clk);
            check("abort_psel_s",  psel_s,   4'b0);
            check("abort_flag",    tmo_flag, 1'b1);
            check("abort_port",    tmo_port, 4'(idx));
            @(posedge reg_clk); #1;
        end
        psel = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int          pi;
        reg_rstn  = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        paddr     = '0;
        pready_s  = '0;
        pslverr_s = '0;
        prdata_s  = '0;
        tmo_clr   = 1'b0;
        repeat (3) @(negedge reg_clk);
        check("rst_err_cnt",  err_cnt,  8'd0);
        check("rst_tmo_flag", tmo_flag, 1'b0);
        check("rst_tmo_port", tmo_port, 4'd0);
        @(posedge reg_clk); #1;
        reg_rstn = 1'b1;

        xfer(32'h0000_1004, 2,  32'hA5A5_0001, 1'b0, 1'b0);
        xfer(32'h0000_2000, 0,  32'h1234_5678, 1'b0, 1'b0);
        xfer(32'h0000_3000, 20, 32'hDEAD_BEEF, 1'b0, 1'b0);
        xfer(32'h0000_3000, 7,  32'h0BAD_F00D, 1'b0, 1'b0);
        xfer(32'h0000_3010, 12, 32'h5555_AAAA, 1'b0, 1'b1);

        // Reset during the 5th wait cycle of a port-0 access.
        @(posedge reg_clk); #1;
        paddr = 32'h0000_0010; psel = 1'b1; penable = 1'b0; pready_s = '0;
        @(posedge reg_clk); #1;
        penable = 1'b1;
        @(negedge reg_clk);
        check("pre_rst_err_cnt", err_cnt, m_err);
        repeat (4) @(posedge reg_clk);
        #1 reg_rstn = 1'b0;
        @(negedge reg_clk);
        check("midrst_err_cnt",  err_cnt,  8'd0);
        check("midrst_tmo_flag", tmo_flag, 1'b0);
        check("midrst_tmo_port", tmo_port, 4'd0);
        check("midrst_pready",   pready,   1'b0);
        @(posedge reg_clk); #1;
        reg_rstn = 1'b1; psel = 1'b0; penable = 1'b0;
        m_err = '0; m_flag = 1'b0; m_port = '0;
        xfer(32'h0000_1008, 3, 32'h0F0F_1234, 1'b0, 1'b0);

        for (int t = 0; t < 80; t++) begin
            r  = $urandom;
            pi = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 15));
            r[15:12] = 4'(pi);
            xfer(r, int'($urandom_range(0, 11)), $urandom, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        for (int t = 0; t < 256; t++) begin
            r = $urandom;
            r[15:12] = (t % 2 == 0) ? 4'd2 : 4'(4 + (t % 12));
            xfer(r, 0, $urandom, 1'b0, 1'b0);
        end
        @(negedge reg_clk);
        check("sat_err_cnt", err_cnt, 8'd255);
        @(posedge reg_clk); #1;
        tmo_clr = 1'b1;
        @(posedge reg_clk); #1;
        tmo_clr = 1'b0;
        m_err = '0; m_flag = 1'b0;
        @(negedge reg_clk);
        check("clr_err_cnt",  err_cnt,  8'd0);
        check("clr_tmo_flag", tmo_flag, 1'b0);

        xfer(32'h0000_0100, 9, 32'hCAFE_0000, 1'b1, 1'b0);
        repeat (3) @(negedge reg_clk);
        check("end_err_cnt",  err_cnt,   m_err);
        check("end_tmo_flag", tmo_flag,  m_flag);
        check("end_tmo_port", tmo_port,  m_port);
        check("sb_drained",   sb.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_slave_mux_tmo.md
APB_SLAVE_MUX_TMO -- requirements
Module: apb_slave_mux_tmo

Interface
REQ-001 The block SHALL have parameter NPORT, default 4, the number of slave ports (1..16).
REQ-002 The block SHALL have parameter DEC_LSB, default 12, the lowest paddr bit used for port decode.
REQ-003 The block SHALL have parameter DEC_W, default 4, the decode field width (NPORT <= 2^DEC_W).
REQ-004 The block SHALL have parameter PORT_EN, default {NPORT{1'b1}}, a per-port enable mask.
REQ-005 The block SHALL have parameter TMO_CYCLES, default 256, the access-phase wait limit (>= 2).
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset, named as listed in REQ-007 and REQ-008.
REQ-007 reg_clk  in  1  is the APB domain clock.
REQ-008 reg_rstn  in  1  is the asynchronous active-low reset.
REQ-009 psel, penable  in  1  are the master select and enable.
REQ-010 paddr  in  32  is the master address.
REQ-011 pready, pslverr  out  1  are the master-side response.
REQ-012 prdata  out  32  is the master-side read data.
REQ-013 psel_s  out  NPORT  is the per-slave select.
REQ-014 pready_s, pslverr_s  in  NPORT  are the per-slave responses.
REQ-015 prdata_s  in  32*NPORT  is the per-slave read data, with port i at bits [32*i+31:32*i].
REQ-016 tmo_clr  in  1  is a single-cycle pulse that clears the timeout status.
REQ-017 tmo_flag  out  1  is the sticky timeout flag.
REQ-018 tmo_port  out  DEC_W  is the port index of the last timeout.
REQ-019 err_cnt  out  8  is a saturating count of error responses.

Function
REQ-020 The decode index SHALL be idx = paddr[DEC_LSB +: DEC_W].
REQ-021 The decode SHALL be valid when idx < NPORT and PORT_EN[idx]=1.
REQ-022 When the decode is valid, psel_s[idx] SHALL equal psel, and all other psel_s bits SHALL be 0.
REQ-023 Each psel_s bit SHALL be forced to 0 in the cycle after a timeout response, until psel falls.
REQ-024 With psel=0, the outputs SHALL be pready=1, pslverr=0, prdata=0.
REQ-025 With psel=1 and a valid decode, pready, pslverr and prdata SHALL be passed through combinationally from port idx (zero added latency).
REQ-026 With psel=1 and an invalid decode, the outputs SHALL be pready=1, pslverr=1, prdata=0, giving a zero-wait error.
REQ-027 The wait counter wcnt (ceil(log2(TMO_CYCLES)) bits) SHALL increment on each cycle with psel and penable high, a valid decode, and pready_s[idx]=0.
REQ-028 wcnt SHALL clear to 0 when psel=0 or when the master-side pready=1.
REQ-029 The FSM SHALL have states IDLE, ACCESS and ABORT.
REQ-030 IDLE SHALL go to ACCESS on psel&penable with a valid decode.
REQ-031 ACCESS SHALL go to IDLE when pready_s[idx]=1.
REQ-032 ACCESS SHALL go to ABORT when wcnt == TMO_CYCLES-1 and pready_s[idx]=0.
REQ-033 ABORT SHALL go to IDLE when psel=0.
REQ-034 On the ACCESS->ABORT cycle, the outputs SHALL be pready=1, pslverr=1, prdata=0, i.e. on the TMO_CYCLES-th access cycle.
REQ-035 On the ACCESS->ABORT cycle, tmo_flag SHALL be set and tmo_port SHALL be set to idx.
REQ-036 If the slave asserts pready_s[idx] in the same cycle that wcnt reaches TMO_CYCLES-1, the slave response SHALL win; no timeout SHALL occur and no flag SHALL be set.
REQ-037 If tmo_clr and a new timeout occur in the same cycle, the set SHALL win.
REQ-038 err_cnt SHALL increment by 1 for each completed transfer with master-side pslverr=1 (unmapped, slave error or timeout).
REQ-039 err_cnt SHALL saturate at 255.
REQ-040 tmo_clr SHALL also clear err_cnt to 0, with an increment in the same cycle giving 1.
REQ-041 A new setup phase that arrives while in ABORT SHALL be ignored until psel has been low for at least one cycle.

Reset
REQ-042 Asserting reg_rstn low SHALL asynchronously force FSM=IDLE, wcnt=0, tmo_flag=0, tmo_port=0 and err_cnt=0.
REQ-043 A reset mid-transfer SHALL abandon the transfer, and the outputs SHALL then follow REQ-022 to REQ-026 from current inputs.
REQ-044 Reset release SHALL be synchronised externally; the block SHALL not include a synchroniser.

Configuration
REQ-045 The macro APB_MUX_TMO_EN SHALL compile in the timeout logic: wcnt, the ABORT state, tmo_flag, tmo_port and REQ-023.
REQ-046 With APB_MUX_TMO_EN undefined, transfers SHALL wait indefinitely, tmo_flag and tmo_port SHALL be tied to 0, and err_cnt SHALL still count unmapped and slave errors.

Verification
REQ-047 Read port 1 (paddr=0x00001004), slave 1 ready after 2 waits with data 0xA5A5_0001 -> psel_s=4'b0010, prdata=0xA5A5_0001, pslverr=0, err_cnt unchanged.
REQ-048 Access with PORT_EN=4'b1011 and paddr=0x00002000 -> psel_s=0, pready=1 and pslverr=1 in the first access cycle, err_cnt=1.
REQ-049 TMO_CYCLES=8, port 3 never ready -> on access cycle 8 pready=1 and pslverr=1, tmo_flag=1, tmo_port=3, psel_s[3]=0 on the next cycle.
REQ-050 TMO_CYCLES=8, slave pready on access cycle 8 -> normal completion, tmo_flag=0.
REQ-051 256 unmapped accesses, then tmo_clr -> err_cnt holds at 255, then reads 0.
REQ-052 reg_rstn low during the 5th wait cycle -> wcnt, tmo_flag and err_cnt all read 0, and the next access completes normally.
